instr_ptr_stack: RTL
====================

# instr_ptr_stack

Parametrised instruction pointer with a hardware call/return stack for the distributed processor core. It keeps the single-cycle combinational load path of the existing pointer: a load asserted in cycle N appears on `ptr_out` in cycle N. It adds subroutine call/return, configurable stack depth, reset vector and error flags. It sits between the instruction decoder (control strobes) and instruction memory (`ptr_out` drives the read address).

## Interface
Parameters:
- `WIDTH`, 8: pointer width in bits.
- `STACK_DEPTH`, 4: return-stack entries; must be at least 1.
- `RESET_ADDR`, 0: pointer value during and after reset.
- `TRAP_ADDR`, all ones: trap vector; used only with `IPTR_STACK_TRAP_EN`.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `enable`  in  1  advance pointer by one.
- `jump_en`  in  1  load `jump_addr` (plain jump).
- `call_en`  in  1  load `jump_addr` and push return address.
- `ret_en`  in  1  pop stack top into pointer.
- `jump_addr`  in  WIDTH  jump/call target.
- `err_clr`  in  1  clear sticky error flags.
- `ptr_out`  out  WIDTH  current instruction address (combinational).
- `stack_level`  out  clog2(STACK_DEPTH+1)  occupied entries.
- `stack_full`  out  1  `stack_level == STACK_DEPTH`.
- `stack_empty`  out  1  `stack_level == 0`.
- `err_ovf`  out  1  sticky: call attempted while full.
- `err_unf`  out  1  sticky: return attempted while empty.

## Operation
- State registers:
  - `prev_val` and `prev_inc`; each cycle `prev_val <= ptr_out` and `prev_inc <= ptr_out + 1`, wrapping modulo 2^WIDTH.
  - The stack array, a stack pointer and the two error flags.
- `ptr_out` is combinational, with priority ret > call > jump > enable > hold:
  - **ret**, stack non-empty: top entry; stack pops.
  - **ret**, stack empty: `prev_val` (hold); sets `err_unf`.
  - **call**: `jump_addr`; pushes `prev_inc`. When full, the push is dropped, the jump is still taken, the stack is unchanged and `err_ovf` is set.
  - **jump**: `jump_addr`; stack unchanged.
  - **enable**: `prev_inc`.
  - **none**: `prev_val`.
- Lower-priority strobes in the same cycle are ignored and do not set any error flag. For example, call+ret together is a pop only.
- The pushed return address is always `prev_inc`, independent of `enable`.
- `stack_level` increments on a push and decrements on a pop. It never exceeds `STACK_DEPTH` and never goes below 0.
- `err_ovf` and `err_unf` stay set until `err_clr` or `reset`. If `err_clr` and a new error occur in the same cycle, the flag ends set.
- Reset:
  - While `reset` is high, `ptr_out = RESET_ADDR` and all strobes are ignored.
  - Registers go to `prev_val = RESET_ADDR`, `prev_inc = RESET_ADDR + 1`, `stack_level = 0`, both errors 0.
  - Reset mid-subroutine discards all stack contents.
- Outputs during reset: `stack_empty = 1`, `stack_full = 0`.

## Timing
- Jump/call/ret/enable take effect on `ptr_out` in the same cycle the strobe is high (zero latency). The registered state updates at the next `clk` edge.
- Stack push/pop is visible on `stack_level` one cycle after the strobe.
- Error flags assert one cycle after the offending strobe.
- First cycle after reset deasserts with no strobes: `ptr_out = RESET_ADDR`. The next cycle with `enable`: `RESET_ADDR + 1`.
- `ptr_out = 2^WIDTH - 1` with `enable` gives 0 the following cycle.
- Call in cycle N with `stack_level = STACK_DEPTH - 1` makes `stack_full` high from cycle N+1.

## Configuration
- `IPTR_STACK_TRAP_EN` defined:
  - Overflow and underflow also redirect `ptr_out` to `TRAP_ADDR` in the same cycle, overriding the call target or the hold.
  - The stack is unchanged.
- Not defined: behaviour exactly as in Operation. `TRAP_ADDR` is unused.

## Test plan
- **Reset then run.** Reset 2 cycles, then `enable` for 5 cycles (`WIDTH = 8`, `RESET_ADDR = 0x10`) -> `ptr_out` 0x10, 0x11…0x15; `stack_empty = 1`.
- **Jump.** `jump_en`, `jump_addr = 0x40` in cycle N -> `ptr_out = 0x40` in cycle N; 0x41 in N+1 with `enable`; `stack_level` stays 0.
- **Nested calls and returns.** With `ptr_out = 0x05`, call 0x20, enable, call 0x30, enable, then ret, ret -> `ptr_out` 0x20, 0x21, 0x30, 0x31, 0x22, 0x06. `stack_level` 1, 1, 2, 2, 1, 0.
- **Overflow.** Four calls fill `STACK_DEPTH = 4` and `stack_full = 1`; a fifth call to 0x55 -> without the macro `ptr_out = 0x55`; with it `ptr_out = TRAP_ADDR`. `err_ovf = 1` next cycle, `stack_level = 4`; `err_clr` clears the flag.
- **Underflow.** Ret with the stack empty at `ptr_out = 0x33` -> `ptr_out = 0x33` (or `TRAP_ADDR` with the macro); `err_unf = 1`.
- **Reset mid-subroutine and wrap.** Reset with `stack_level = 2` -> `stack_level = 0`, `ptr_out = RESET_ADDR`. Separately, jump to 0xFF then `enable` -> 0x00.

Source files
------------

// File: rtl/instr_ptr_stack.sv
// Instruction pointer with a zero-latency load path and a hardware call/return stack.
// Optional feature macro: IPTR_STACK_TRAP_EN (overflow/underflow redirect ptr_out to TRAP_ADDR).
module instr_ptr_stack #(
    parameter int               WIDTH       = 8,
    parameter int               STACK_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_ADDR  = '0,
    parameter logic [WIDTH-1:0] TRAP_ADDR   = '1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               enable,
    input  logic                               jump_en,
    input  logic                               call_en,
    input  logic                               ret_en,
    input  logic [WIDTH-1:0]                   jump_addr,
    input  logic                               err_clr,
    output logic [WIDTH-1:0]                   ptr_out,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_level,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               err_ovf,
    output logic                               err_unf
);

    localparam int             LW      = $clog2(STACK_DEPTH + 1);
    localparam logic [LW-1:0]  DEPTH_L = LW'(STACK_DEPTH);

`ifdef IPTR_STACK_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif

    logic [WIDTH-1:0] prev_val;
    logic [WIDTH-1:0] prev_inc;
    logic [WIDTH-1:0] top_val;
    logic [WIDTH-1:0] mem [STACK_DEPTH];
    logic [LW-1:0]    level;
    logic [LW-1:0]    level_m1;
    logic             full_i;
    logic             empty_i;
    logic             push;
    logic             pop;
    logic             set_ovf;
    logic             set_unf;

    assign full_i   = (level == DEPTH_L);
    assign empty_i  = (level == '0);
    assign level_m1 = level - LW'(1);

    // Compare-based selection keeps the array exactly STACK_DEPTH entries for any depth.
    always_comb begin
        top_val = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (LW'(i) == level_m1) top_val = mem[i];
        end
    end

    always_comb begin
        ptr_out = prev_val;
        push    = 1'b0;
        pop     = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        if (reset) begin
            ptr_out = RESET_ADDR;
        end else if (ret_en) begin
            if (!empty_i) begin
                ptr_out = top_val;
                pop     = 1'b1;
            end else begin
                ptr_out = TRAP_ON ? TRAP_ADDR : prev_val;
                set_unf = 1'b1;
            end
        end else if (call_en) begin
            if (!full_i) begin
                ptr_out = jump_addr;
                push    = 1'b1;
            end else begin
                ptr_out = TRAP_ON ? TRAP_ADDR : jump_addr;
                set_ovf = 1'b1;
            end
        end else if (jump_en) begin
            ptr_out = jump_addr;
        end else if (enable) begin
            ptr_out = prev_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_val <= RESET_ADDR;
            prev_inc <= RESET_ADDR + WIDTH'(1);
            level    <= '0;
            err_ovf  <= 1'b0;
            err_unf  <= 1'b0;
        end else begin
            prev_val <= ptr_out;
            prev_inc <= ptr_out + WIDTH'(1);
            if (push) begin
                level <= level + LW'(1);
            end else if (pop) begin
                level <= level - LW'(1);
            end
            // A new error in the same cycle as err_clr wins.
            if (set_ovf)      err_ovf <= 1'b1;
            else if (err_clr) err_ovf <= 1'b0;
            if (set_unf)      err_unf <= 1'b1;
            else if (err_clr) err_unf <= 1'b0;
        end
    end

    // Return address is always the sequential successor of the previous pointer.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (push && (LW'(i) == level)) mem[i] <= prev_inc;
        end
    end

    assign stack_level = level;
    assign stack_full  = !reset && full_i;
    assign stack_empty = reset || empty_i;

endmodule
